// File: rtl/div_result_bcd.sv
// Purpose : binary-to-BCD converter for the 8-bit divider result (quotient and remainder in parallel, double-dabble).
// Latency : W+1 edges from acceptance to out_valid (1 edge when div_zero is reported).
// Backpressure: holds the result in DONE while out_ready is low; in_ready is high only in IDLE.
// Optional: define DIV_BCD_LZ_BLANK_EN to replace leading zero digits with the 4'hF blank code.
module div_result_bcd #(
  parameter int W  = 8,
  parameter int D  = 3,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   quotient,
  input  logic [W-1:0]   remainder,
  input  logic           div_zero,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] q_bcd,
  output logic [4*D-1:0] r_bcd,
  output logic           out_div_zero,
  output logic           busy
);

  // Scratch register layout: {bcd digits (4*D bits), binary operand (W bits)}
  localparam int SW = 4*D + W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   q_sh;
  logic [SW-1:0]   r_sh;
  logic [SW-1:0]   q_nxt;
  logic [SW-1:0]   r_nxt;
  logic            last_shift;

  // One double-dabble iteration: +3 on every nibble >= 5, then shift the whole register left.
  // Corrections are independent per nibble; the only inter-nibble movement is the shift itself.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] v);
    logic [SW-1:0] t;
    t = v;
    for (int i = 0; i < D; i++) begin
      if (t[W+4*i +: 4] >= 4'd5) begin
        t[W+4*i +: 4] = t[W+4*i +: 4] + 4'd3;
      end
    end
    return {t[SW-2:0], 1'b0};
  endfunction

`ifdef DIV_BCD_LZ_BLANK_EN
  // Blank leading zero digits (most significant first); the units digit is always shown.
  function automatic logic [4*D-1:0] present_digits(input logic [4*D-1:0] d);
    logic [4*D-1:0] t;
    logic           leading;
    t       = d;
    leading = 1'b1;
    for (int i = D-1; i >= 1; i--) begin
      if (leading && (t[4*i +: 4] == 4'h0)) begin
        t[4*i +: 4] = 4'hF;
      end else begin
        leading = 1'b0;
      end
    end
    return t;
  endfunction
`else
  // Plain BCD: digits are presented unchanged, zeros kept.
  function automatic logic [4*D-1:0] present_digits(input logic [4*D-1:0] d);
    return d;
  endfunction
`endif

  // Next iteration of both scratch registers and the final-shift detect.
  always_comb begin
    q_nxt      = dabble_step(q_sh);
    r_nxt      = dabble_step(r_sh);
    last_shift = (cnt == CW'(W-1));
  end

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      q_sh         <= '0;
      r_sh         <= '0;
      q_bcd        <= '0;
      r_bcd        <= '0;
      out_div_zero <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (div_zero) begin
              // No conversion needed: present zero digits with the flag set.
              state        <= S_DONE;
              q_bcd        <= present_digits('0);
              r_bcd        <= present_digits('0);
              out_div_zero <= 1'b1;
              out_valid    <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
              cnt   <= '0;
              q_sh  <= {{(4*D){1'b0}}, quotient};
              r_sh  <= {{(4*D){1'b0}}, remainder};
            end
          end
        end

        S_SHIFT: begin
          q_sh <= q_nxt;
          r_sh <= r_nxt;
          cnt  <= cnt + 1'b1;
          if (last_shift) begin
            // Outputs change only here, so the readout never sees partial digits.
            state        <= S_DONE;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
            q_bcd        <= present_digits(q_nxt[SW-1:W]);
            r_bcd        <= present_digits(r_nxt[SW-1:W]);
            out_div_zero <= 1'b0;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 8-bit divider.
- Captures one {quotient, remainder, div_zero} result per handshake and converts quotient and remainder in parallel with the shift-add-3 (double-dabble) algorithm, one bit per cycle.
- Presents packed BCD digits to the display/readout stage over a valid/ready interface.

Parameters:
- W, 8, binary width of quotient and remainder.
- D, 3, BCD digits per operand; must satisfy 10^D > 2^W - 1.
- CW, 4, width of the iteration counter; must satisfy 2^CW > W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept a result (IDLE only).
- quotient  in  W  divider quotient.
- remainder  in  W  divider remainder.
- div_zero  in  1  divider reported divisor == 0.
- out_valid  out  1  BCD result available.
- out_ready  in  1  downstream accepts result.
- q_bcd  out  4*D  quotient digits; [3:0] = units, [7:4] = tens, [11:8] = hundreds.
- r_bcd  out  4*D  remainder digits, same packing as q_bcd.
- out_div_zero  out  1  registered copy of the captured div_zero.
- busy  out  1  high in SHIFT.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - state = IDLE, counter = 0, shift registers = 0.
  - Outputs: out_valid = 0, q_bcd = 0, r_bcd = 0, out_div_zero = 0, busy = 0.
  - in_ready = 1 in the cycle after reset is released.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture quotient, remainder and div_zero.
  - div_zero = 1: go to DONE, q_bcd = r_bcd = 0, out_div_zero = 1. Latency 1 cycle.
  - div_zero = 0: load the binary values into the low W bits of each scratch register {bcd, bin}, clear the BCD parts and counter, go to SHIFT.
- State SHIFT, one iteration per cycle for both operands simultaneously:
  - Each BCD nibble >= 5 gets +3.
  - Then the whole {bcd, bin} register shifts left by 1.
  - Counter increments; when counter reaches W-1 (i.e. on the W-th shift), go to DONE.
  - Outputs update only on entry to DONE, never mid-conversion.
  - Total latency is W+1 = 9 rising edges from acceptance to out_valid.
  - in_ready = 0; in_valid is ignored.
- State DONE:
  - out_valid = 1.
  - q_bcd, r_bcd and out_div_zero are held stable while out_ready = 0.
  - On out_ready = 1, go to IDLE; out_valid drops on the next edge.
  - in_ready stays 0 in DONE; no pass-through of a new result in the same cycle.
  - Maximum throughput is one result per W+2 cycles.
- Arithmetic:
  - The +3 correction is applied per nibble, in the same cycle, before the shift.
  - No carries propagate between nibbles outside the shift.
- Boundaries:
  - 0 -> 000.
  - 255 -> 2,5,5.
  - Quotient and remainder are independent; both finish on the same cycle.
- Reset asserted during SHIFT or DONE aborts the conversion; the result is discarded and never presented.
- out_ready asserted in IDLE or SHIFT has no effect.

Optional Feature:
- Macro DIV_BCD_LZ_BLANK_EN.
- Defined: on entry to DONE, leading zero digits of q_bcd and r_bcd (hundreds; tens if hundreds is also zero) are replaced by 4'hF, the blank code for the seven-segment decoder. The units digit is never blanked. A div_zero result becomes F,F,0 for both operands.
- Undefined: digits are plain BCD with zeros kept; no extra logic.

Test Plan:
- quotient = 255, remainder = 0, div_zero = 0, out_ready = 1 -> out_valid 9 edges after acceptance, q_bcd = 12'h255, r_bcd = 12'h000, out_div_zero = 0.
- quotient = 100, remainder = 9 -> q_bcd = 12'h100, r_bcd = 12'h009; busy high for exactly 8 cycles.
- div_zero = 1 (other inputs arbitrary) -> out_valid 1 edge after acceptance, q_bcd = r_bcd = 0, out_div_zero = 1.
- Backpressure: quotient = 37, out_ready = 0 for 5 cycles -> out_valid and q_bcd = 12'h037 stable throughout, in_ready = 0, a second in_valid pulse is ignored; out_ready = 1 -> IDLE next cycle.
- rst pulsed on the 4th SHIFT cycle -> next cycle IDLE, out_valid = 0, outputs 0; a following result converts correctly.
- With DIV_BCD_LZ_BLANK_EN defined: quotient = 7, remainder = 42 -> q_bcd = 12'hFF7, r_bcd = 12'hF42.
